// File: rtl/counter_parametric.sv
// Enable-gated modulo counter: counts 0..COUNT, then wraps to 0.
// Asynchronous active-low reset on rst; at_max flags the terminal value.
module counter_parametric #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] COUNT = 8'd255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] counter,
    output logic             at_max
);

    logic [WIDTH-1:0] counter_next;

    // Comparing with >= rather than == also pulls an out-of-range value back to 0.
    always_comb begin
        counter_next = counter;
        if (en) begin
            if (counter >= COUNT) begin
                counter_next = '0;
            end else begin
                counter_next = counter + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= '0;
        end else begin
            counter <= counter_next;
        end
    end

    assign at_max = (counter == COUNT);

endmodule

// File: tb/tb_counter_parametric.sv
// Self-checking bench for counter_parametric: three instances (COUNT=255/W8,
// COUNT=5/W4, COUNT=0/W4) checked against a modulo-arithmetic reference model.
module tb_counter_parametric;

    localparam int CA = 255;
    localparam int CB = 5;
    localparam int CC = 0;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic       en_a, en_b, en_c;
    logic [7:0] cnt_a;
    logic [3:0] cnt_b, cnt_c;
    logic       max_a, max_b, max_c;

    int ma, mb, mc;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_parametric #(.WIDTH(8), .COUNT(8'd255)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .counter(cnt_a), .at_max(max_a)
    );
    counter_parametric #(.WIDTH(4), .COUNT(4'd5)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .counter(cnt_b), .at_max(max_b)
    );
    counter_parametric #(.WIDTH(4), .COUNT(4'd0)) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .counter(cnt_c), .at_max(max_c)
    );

    // Advance one clock and update the reference model from the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ma = !rst_a ? 0 : (en_a ? (ma + 1) % (CA + 1) : ma);
        mb = !rst_b ? 0 : (en_b ? (mb + 1) % (CB + 1) : mb);
        mc = !rst_c ? 0 : (en_c ? (mc + 1) % (CC + 1) : mc);
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
    endtask

    task automatic reset_b();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_a;
        tick();
        tick();
        checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 4'd0 || cnt_c !== 4'd0) begin
            errors++;
            $display("FAIL reset_counts a=%0d b=%0d c=%0d required 0 0 0", cnt_a, cnt_b, cnt_c);
        end
        checks++;
        if (max_a !== 1'b0 || max_b !== 1'b0 || max_c !== 1'b1) begin
            errors++;
            $display("FAIL reset_at_max a=%b b=%b c=%b required 0 0 1", max_a, max_b, max_c);
        end
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a = 1'b1;
        repeat (3) tick();
        exp_a = 8'(ma);
        checks++;
        if (cnt_a !== exp_a || exp_a !== 8'd3) begin
            errors++;
            $display("FAIL pre_async_count got=%0d required=3", cnt_a);
        end
        // Asynchronous pulse between clock edges with en still high.
        #2 rst_a = 1'b0;
        #1;
        ma = 0;
        checks++;
        if (cnt_a !== 8'd0 || max_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset cnt=%0d at_max=%b required 0 0", cnt_a, max_a);
        end
        tick();
        rst_a = 1'b1;
        en_a = 1'b0;
    endtask

    task automatic test_full_sweep();
        logic [7:0] exp_a;
        reset_a();
        en_a = 1'b1;
        checks++;
        if (cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL sweep_start got=%0d required=0", cnt_a);
        end
        for (int i = 1; i <= 257; i++) begin
            tick();
            exp_a = 8'(i % 256);
            checks++;
            if (cnt_a !== exp_a || max_a !== (exp_a == 8'd255)) begin
                errors++;
                $display("FAIL sweep step=%0d cnt=%0d at_max=%b required %0d %b",
                         i, cnt_a, max_a, exp_a, (exp_a == 8'd255));
            end
        end
        checks++;
        if (ma != 1) begin
            errors++;
            $display("FAIL sweep_model_end model=%0d required=1", ma);
        end
        en_a = 1'b0;
    endtask

    task automatic test_short_modulus();
        reset_b();
        en_b = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (cnt_b !== 4'(i % 6) || cnt_b > 4'd5 || max_b !== (i % 6 == 5)) begin
                errors++;
                $display("FAIL short_mod step=%0d cnt=%0d at_max=%b required %0d %b",
                         i, cnt_b, max_b, i % 6, (i % 6 == 5));
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_enable_gating();
        logic [3:0] resume [3];
        resume[0] = 4'd4; resume[1] = 4'd5; resume[2] = 4'd0;
        reset_b();
        en_b = 1'b1;
        repeat (3) tick();
        checks++;
        if (cnt_b !== 4'd3) begin
            errors++;
            $display("FAIL gate_reach3 got=%0d required=3", cnt_b);
        end
        en_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cnt_b !== 4'd3) begin
                errors++;
                $display("FAIL gate_hold cycle=%0d got=%0d required=3", i, cnt_b);
            end
        end
        en_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cnt_b !== resume[i]) begin
                errors++;
                $display("FAIL gate_resume step=%0d got=%0d required=%0d", i, cnt_b, resume[i]);
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_mid_reset();
        int budget;
        reset_a();
        en_a = 1'b1;
        budget = 0;
        while (ma != 100 && budget < 200) begin
            tick();
            budget++;
        end
        checks++;
        if (cnt_a !== 8'd100) begin
            errors++;
            $display("FAIL mid_reach100 got=%0d required=100 cycles=%0d", cnt_a, budget);
        end
        #1 rst_a = 1'b0;
        #1;
        ma = 0;
        checks++;
        if (cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL mid_async got=%0d required=0", cnt_a);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (cnt_a !== 8'd0) begin
                errors++;
                $display("FAIL mid_held cycle=%0d got=%0d required=0", i, cnt_a);
            end
        end
        rst_a = 1'b1;
        en_a = 1'b1;
        tick();
        checks++;
        if (cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL mid_release got=%0d required=1", cnt_a);
        end
        en_a = 1'b0;
    endtask

    task automatic test_degenerate();
        en_c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (cnt_c !== 4'd0 || max_c !== 1'b1) begin
                errors++;
                $display("FAIL degenerate cycle=%0d cnt=%0d at_max=%b required 0 1", i, cnt_c, max_c);
            end
        end
        en_c = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en_a = 1'($urandom);
            en_b = 1'($urandom);
            en_c = 1'($urandom);
            rst_b = ($urandom_range(0, 31) != 0);
            if (!rst_b) begin
                #1;
                mb = 0;
            end
            tick();
            checks++;
            if (cnt_a !== 8'(ma) || max_a !== (ma == CA)) begin
                errors++;
                $display("FAIL random_a step=%0d cnt=%0d at_max=%b required %0d %b",
                         i, cnt_a, max_a, ma, (ma == CA));
            end
            checks++;
            if (cnt_b !== 4'(mb) || max_b !== (mb == CB)) begin
                errors++;
                $display("FAIL random_b step=%0d cnt=%0d at_max=%b required %0d %b",
                         i, cnt_b, max_b, mb, (mb == CB));
            end
            checks++;
            if (cnt_c !== 4'(mc) || max_c !== 1'b1) begin
                errors++;
                $display("FAIL random_c step=%0d cnt=%0d at_max=%b required %0d 1",
                         i, cnt_c, max_c, mc);
            end
        end
        rst_b = 1'b1;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a = 1'b0;  en_b = 1'b0;  en_c = 1'b0;
        ma = 0; mb = 0; mc = 0;
        test_reset();
        test_full_sweep();
        test_short_modulus();
        test_enable_gating();
        test_mid_reset();
        test_degenerate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
